branch_issue_queue: RTL and testbench

In-order issue queue for branch and JIRL micro-ops, sitting directly upstream of the branch resolution unit (BRU). Holds up to DEPTH dispatched branches and captures missing source operands from the writeback buses. Issues the oldest entry with a single-cycle valid pulse once both operands are present, presenting the exact operand bundle the BRU consumes. Cleared entirely by `flush_back`.

---
 rtl/branch_issue_queue.sv | 179 +++++++++++++++++
 tb/tb_branch_issue_queue.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_issue_queue.sv
// In-order issue queue for branch/JIRL micro-ops feeding the BRU.
// Entries capture missing operands from two writeback ports. The oldest entry
// issues with a one-cycle `ready` pulse once both of its operands are present.
module branch_issue_queue #(
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush_back,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [3:0]               in_Conf,
   input  logic [31:0]              in_imm,
   input  logic [31:0]              in_target_predict,
   input  logic [5:0]               in_tag_rob,
   input  logic [5:0]               in_preg_j,
   input  logic [5:0]               in_preg_d,
   input  logic                     in_rdy_j,
   input  logic                     in_rdy_d,
   input  logic [31:0]              in_data_j,
   input  logic [31:0]              in_data_d,
   input  logic [1:0]               wb_valid,
   input  logic [11:0]              wb_preg,
   input  logic [63:0]              wb_data,
   output logic [31:0]              dataj,
   output logic [31:0]              datad_old,
   output logic [3:0]               Conf,
   output logic [31:0]              imm,
   output logic [31:0]              target_predict,
   output logic                     ready,
   output logic [5:0]               tag_rob,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   typedef struct packed {
      logic        valid;
      logic [3:0]  conf;
      logic [31:0] imm;
      logic [31:0] tgt;
      logic [5:0]  tag;
      logic [5:0]  preg_j;
      logic        rdy_j;
      logic [31:0] data_j;
      logic [5:0]  preg_d;
      logic        rdy_d;
      logic [31:0] data_d;
   } entry_t;

   entry_t          ent_q [DEPTH];
   entry_t          ent_d [DEPTH];
   logic [PW-1:0]   head_q, head_d;
   logic [PW-1:0]   tail_q, tail_d;
   logic [CW-1:0]   count_q, count_d;

   // {hit, data} per stored source and for the incoming dispatch
   logic [32:0]     wake_j [DEPTH];
   logic [32:0]     wake_d [DEPTH];
   logic [32:0]     enq_wake_j, enq_wake_d;

   entry_t          head_ent;
   logic            enq, iss;

   // Match a source tag against both writeback ports; port 0 has priority.
   function automatic logic [32:0] wb_lookup(input logic [5:0]  preg,
                                             input logic [1:0]  v,
                                             input logic [11:0] p,
                                             input logic [63:0] d);
      logic [32:0] res;
      res = '0;
      if (v[0] && (p[5:0] == preg)) begin
         res = {1'b1, d[31:0]};
      end else if (v[1] && (p[11:6] == preg)) begin
         res = {1'b1, d[63:32]};
      end
      return res;
   endfunction

   // Writeback tag comparison for every entry and for the dispatch slot.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         wake_j[i] = wb_lookup(ent_q[i].preg_j, wb_valid, wb_preg, wb_data);
         wake_d[i] = wb_lookup(ent_q[i].preg_d, wb_valid, wb_preg, wb_data);
      end
      enq_wake_j = wb_lookup(in_preg_j, wb_valid, wb_preg, wb_data);
      enq_wake_d = wb_lookup(in_preg_d, wb_valid, wb_preg, wb_data);
   end

   // Handshake decode and BRU-facing outputs, zeroed whenever no issue occurs.
   always_comb begin
      head_ent       = ent_q[head_q];
      in_ready       = (count_q < CW'(DEPTH));
      enq            = in_valid && in_ready && !flush_back;
      iss            = head_ent.valid && head_ent.rdy_j && head_ent.rdy_d && !flush_back;
      ready          = iss;
      count          = count_q;
      dataj          = '0;
      datad_old      = '0;
      Conf           = '0;
      imm            = '0;
      target_predict = '0;
      tag_rob        = '0;
      if (iss) begin
         dataj          = head_ent.data_j;
         datad_old      = head_ent.data_d;
         Conf           = head_ent.conf;
         imm            = head_ent.imm;
         target_predict = head_ent.tgt;
         tag_rob        = head_ent.tag;
      end
   end

   // Next-state: wakeup, issue, enqueue, then flush overrides everything.
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      for (int i = 0; i < DEPTH; i++) begin
         ent_d[i] = ent_q[i];
         if (ent_q[i].valid && !ent_q[i].rdy_j && wake_j[i][32]) begin
            ent_d[i].rdy_j  = 1'b1;
            ent_d[i].data_j = wake_j[i][31:0];
         end
         if (ent_q[i].valid && !ent_q[i].rdy_d && wake_d[i][32]) begin
            ent_d[i].rdy_d  = 1'b1;
            ent_d[i].data_d = wake_d[i][31:0];
         end
      end
      if (iss) begin
         ent_d[head_q].valid = 1'b0;
         head_d              = head_q + PW'(1);
      end
      // Tail slot is always free when enq fires, so no overlap with issue.
      if (enq) begin
         ent_d[tail_q].valid  = 1'b1;
         ent_d[tail_q].conf   = in_Conf;
         ent_d[tail_q].imm    = in_imm;
         ent_d[tail_q].tgt    = in_target_predict;
         ent_d[tail_q].tag    = in_tag_rob;
         ent_d[tail_q].preg_j = in_preg_j;
         ent_d[tail_q].rdy_j  = in_rdy_j | enq_wake_j[32];
         ent_d[tail_q].data_j = in_rdy_j ? in_data_j : enq_wake_j[31:0];
         ent_d[tail_q].preg_d = in_preg_d;
         ent_d[tail_q].rdy_d  = in_rdy_d | enq_wake_d[32];
         ent_d[tail_q].data_d = in_rdy_d ? in_data_d : enq_wake_d[31:0];
         tail_d               = tail_q + PW'(1);
      end
      count_d = count_q + CW'(enq) - CW'(iss);
      if (flush_back) begin
         for (int i = 0; i < DEPTH; i++) begin
            ent_d[i].valid = 1'b0;
         end
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            ent_q[i] <= '0;
         end
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         for (int i = 0; i < DEPTH; i++) begin
            ent_q[i] <= ent_d[i];
         end
      end
   end

endmodule

// File: tb/tb_branch_issue_queue.sv
// Bench for branch_issue_queue: table-driven single-dispatch vectors plus
// hand-written multi-cycle sequences; issued bundles checked by a scoreboard.
module tb_branch_issue_queue;

   localparam int unsigned DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush_back;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  in_Conf;
   logic [31:0] in_imm;
   logic [31:0] in_target_predict;
   logic [5:0]  in_tag_rob;
   logic [5:0]  in_preg_j;
   logic [5:0]  in_preg_d;
   logic        in_rdy_j;
   logic        in_rdy_d;
   logic [31:0] in_data_j;
   logic [31:0] in_data_d;
   logic [1:0]  wb_valid;
   logic [11:0] wb_preg;
   logic [63:0] wb_data;
   logic [31:0] dataj;
   logic [31:0] datad_old;
   logic [3:0]  Conf;
   logic [31:0] imm;
   logic [31:0] target_predict;
   logic        ready;
   logic [5:0]  tag_rob;
   logic [2:0]  count;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [3:0]  conf;
      logic [31:0] imm;
      logic [31:0] tgt;
      logic [5:0]  tag;
      logic [31:0] dj;
      logic [31:0] dd;
   } exp_t;

   typedef struct {
      logic [3:0]  conf;
      logic [31:0] imm;
      logic [31:0] tgt;
      logic [5:0]  tag;
      logic [5:0]  pj;
      logic        rj;
      logic [31:0] dj;
      logic [5:0]  pd;
      logic        rd;
      logic [31:0] dd;
      logic [1:0]  wbv;
      logic [11:0] wbp;
      logic [63:0] wbd;
      logic [31:0] exp_j;
      logic [31:0] exp_d;
   } vec_t;

   exp_t sb[$];
   vec_t vecs[7];

   branch_issue_queue #(.DEPTH(DEPTH)) dut (
      .clk               (clk),
      .rst               (rst),
      .flush_back        (flush_back),
      .in_valid          (in_valid),
      .in_ready          (in_ready),
      .in_Conf           (in_Conf),
      .in_imm            (in_imm),
      .in_target_predict (in_target_predict),
      .in_tag_rob        (in_tag_rob),
      .in_preg_j         (in_preg_j),
      .in_preg_d         (in_preg_d),
      .in_rdy_j          (in_rdy_j),
      .in_rdy_d          (in_rdy_d),
      .in_data_j         (in_data_j),
      .in_data_d         (in_data_d),
      .wb_valid          (wb_valid),
      .wb_preg           (wb_preg),
      .wb_data           (wb_data),
      .dataj             (dataj),
      .datad_old         (datad_old),
      .Conf              (Conf),
      .imm               (imm),
      .target_predict    (target_predict),
      .ready             (ready),
      .tag_rob           (tag_rob),
      .count             (count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Scoreboard: every issue pops the oldest expected bundle; idle cycles
   // must present an all-zero bundle.
   always @(negedge clk) begin
      if (rst) begin
         if (ready) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_issue: got tag %0h expected no issue", tag_rob);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("issue_bundle", {Conf, imm, target_predict, tag_rob, dataj, datad_old},
                   {e.conf, e.imm, e.tgt, e.tag, e.dj, e.dd});
            end
         end else begin
            chk("idle_outputs_zero", {Conf, imm, target_predict, tag_rob, dataj, datad_old},
                160'd0);
         end
      end
   end

   task automatic idle();
      in_valid   = 1'b0;
      flush_back = 1'b0;
      wb_valid   = 2'b00;
      wb_preg    = '0;
      wb_data    = '0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input vec_t v);
      in_valid          = 1'b1;
      in_Conf           = v.conf;
      in_imm            = v.imm;
      in_target_predict = v.tgt;
      in_tag_rob        = v.tag;
      in_preg_j         = v.pj;
      in_rdy_j          = v.rj;
      in_data_j         = v.dj;
      in_preg_d         = v.pd;
      in_rdy_d          = v.rd;
      in_data_d         = v.dd;
      wb_valid          = v.wbv;
      wb_preg           = v.wbp;
      wb_data           = v.wbd;
   endtask

   function automatic vec_t mk(input logic [5:0] tag, input logic [5:0] pj, input logic rj,
                               input logic [31:0] dj, input logic [31:0] dd);
      vec_t v;
      v = '{4'h9, {26'd0, tag}, 32'h8000_0000 | {26'd0, tag}, tag, pj, rj, dj, 6'd1, 1'b1, dd,
            2'b00, 12'h000, 64'h0, dj, dd};
      return v;
   endfunction

   task automatic push(input vec_t v);
      exp_t e;
      e = '{v.conf, v.imm, v.tgt, v.tag, v.exp_j, v.exp_d};
      sb.push_back(e);
   endtask

   // One dispatch into an empty queue: issue exactly one cycle later, then empty.
   task automatic run_single(input vec_t v, input string name);
      drive(v);
      push(v);
      @(negedge clk);
      chk({name, "_disp_ready"}, ready, 1'b0);
      chk({name, "_disp_in_ready"}, in_ready, 1'b1);
      step();
      idle();
      @(negedge clk);
      chk({name, "_issue_ready"}, ready, 1'b1);
      step();
      @(negedge clk);
      chk({name, "_after_ready"}, ready, 1'b0);
      chk({name, "_after_count"}, count, 3'd0);
      step();
   endtask

   initial begin
      vec_t v;
      vecs[0] = '{4'h1, 32'h4, 32'h1000, 6'd3, 6'd1, 1'b1, 32'd5, 6'd2, 1'b1, 32'd5,
                  2'b00, 12'h000, 64'h0, 32'd5, 32'd5};
      vecs[1] = '{4'h2, 32'hFFFF_FFF0, 32'h2000, 6'd4, 6'd9, 1'b0, 32'hDEAD, 6'd3, 1'b1,
                  32'h77, 2'b01, {6'd0, 6'd9}, {32'h0, 32'h123}, 32'h123, 32'h77};
      vecs[2] = '{4'h3, 32'h8, 32'h3000, 6'd5, 6'd4, 1'b1, 32'h1, 6'd7, 1'b0, 32'h0,
                  2'b01, {6'd0, 6'd7}, {32'h0, 32'h99}, 32'h1, 32'h99};
      vecs[3] = '{4'h4, 32'h10, 32'h4000, 6'd6, 6'd12, 1'b0, 32'h0, 6'd12, 1'b0, 32'h0,
                  2'b11, {6'd12, 6'd12}, {32'hBB, 32'hAA}, 32'hAA, 32'hAA};
      vecs[4] = '{4'h5, 32'h20, 32'h5000, 6'd7, 6'd20, 1'b0, 32'h0, 6'd8, 1'b1, 32'h42,
                  2'b11, {6'd20, 6'd21}, {32'h5555, 32'h6666}, 32'h5555, 32'h42};
      vecs[5] = '{4'h6, 32'h30, 32'h6000, 6'd8, 6'd4, 1'b1, 32'h11, 6'd5, 1'b1, 32'h12,
                  2'b01, {6'd0, 6'd4}, {32'h0, 32'h22}, 32'h11, 32'h12};
      vecs[6] = '{4'hF, 32'hABCD, 32'h7000, 6'd61, 6'd1, 1'b1, 32'hC0FFEE, 6'd2, 1'b1,
                  32'hBEEF, 2'b00, 12'h000, 64'h0, 32'hC0FFEE, 32'hBEEF};

      rst = 1'b0;
      idle();
      in_Conf = '0; in_imm = '0; in_target_predict = '0; in_tag_rob = '0;
      in_preg_j = '0; in_preg_d = '0; in_rdy_j = 1'b0; in_rdy_d = 1'b0;
      in_data_j = '0; in_data_d = '0;

      // Reset state
      @(negedge clk);
      chk("reset_ready", ready, 1'b0);
      chk("reset_count", count, 3'd0);
      chk("reset_in_ready", in_ready, 1'b1);
      chk("reset_bundle", {Conf, imm, target_predict, tag_rob, dataj, datad_old}, 160'd0);
      step();
      rst = 1'b1;
      step();

      // Table: single dispatches covering rdy, same-cycle wake and port priority
      for (int i = 0; i < 6; i++) begin
         run_single(vecs[i], $sformatf("vec%0d", i));
      end

      // Unready head blocks a ready younger entry until port 1 wakes it
      v = mk(6'd10, 6'd9, 1'b0, 32'h10, 32'h21);
      drive(v); push(v);
      @(negedge clk); chk("order_a_disp", ready, 1'b0);
      step();
      v = mk(6'd11, 6'd2, 1'b1, 32'h31, 32'h32);
      drive(v); push(v);
      @(negedge clk); chk("order_b_disp", ready, 1'b0);
      step();
      idle();
      @(negedge clk); chk("order_blocked", ready, 1'b0);
      chk("order_count2", count, 3'd2);
      step();
      wb_valid = 2'b10; wb_preg = {6'd9, 6'd0}; wb_data = {32'h10, 32'h0};
      @(negedge clk); chk("order_wb_cycle", ready, 1'b0);
      step();
      idle();
      @(negedge clk); chk("order_issue_a", ready, 1'b1);
      step();
      @(negedge clk); chk("order_issue_b", ready, 1'b1);
      step();
      @(negedge clk); chk("order_done_ready", ready, 1'b0);
      chk("order_done_count", count, 3'd0);
      step();

      // Fill to DEPTH with unready entries; extra dispatch is dropped
      for (int i = 0; i < 4; i++) begin
         v = mk(6'(20 + i), 6'(30 + i), 1'b0, 32'(32'h300 + i), 32'(i));
         drive(v); push(v);
         @(negedge clk); chk("fill_in_ready", in_ready, 1'b1);
         step();
      end
      v = mk(6'd63, 6'd1, 1'b1, 32'h1, 32'h2);
      drive(v);
      @(negedge clk);
      chk("full_in_ready", in_ready, 1'b0);
      chk("full_count", count, 3'd4);
      chk("full_ready", ready, 1'b0);
      step();
      idle();
      wb_valid = 2'b11; wb_preg = {6'd31, 6'd30}; wb_data = {32'h301, 32'h300};
      @(negedge clk);
      chk("dropped_count", count, 3'd4);
      chk("wake1_ready", ready, 1'b0);
      step();
      wb_valid = 2'b11; wb_preg = {6'd33, 6'd32}; wb_data = {32'h303, 32'h302};
      @(negedge clk);
      chk("drain0_ready", ready, 1'b1);
      chk("drain0_in_ready", in_ready, 1'b0);
      step();
      idle();
      @(negedge clk);
      chk("drain1_ready", ready, 1'b1);
      chk("drain1_in_ready", in_ready, 1'b1);
      chk("drain1_count", count, 3'd3);
      step();
      @(negedge clk); chk("drain2_ready", ready, 1'b1);
      step();
      @(negedge clk); chk("drain3_ready", ready, 1'b1);
      step();
      @(negedge clk);
      chk("drained_ready", ready, 1'b0);
      chk("drained_count", count, 3'd0);
      step();

      // Pointer wrap with back-to-back ready dispatches
      for (int k = 0; k < 5; k++) begin
         if (k < 4) begin
            v = mk(6'(40 + k), 6'd1, 1'b1, 32'(32'hA00 + k), 32'(32'hB00 + k));
            drive(v); push(v);
         end else begin
            idle();
         end
         @(negedge clk);
         chk($sformatf("wrap%0d_ready", k), ready, (k > 0));
         step();
      end
      @(negedge clk);
      chk("wrap_done_ready", ready, 1'b0);
      chk("wrap_done_count", count, 3'd0);
      step();

      // Flush with three queued entries and a concurrent dispatch
      for (int i = 0; i < 3; i++) begin
         v = mk(6'(1 + i), 6'(50 + i), 1'b0, 32'h500, 32'(i));
         drive(v); push(v);
         step();
      end
      idle();
      wb_valid = 2'b01; wb_preg = {6'd0, 6'd50}; wb_data = {32'h0, 32'h500};
      @(negedge clk); chk("preflush_ready", ready, 1'b0);
      step();
      v = mk(6'd60, 6'd1, 1'b1, 32'h6, 32'h7);
      drive(v);
      flush_back = 1'b1;
      @(negedge clk); chk("flush_cycle_ready", ready, 1'b0);
      sb.delete();
      step();
      idle();
      @(negedge clk);
      chk("postflush_count", count, 3'd0);
      chk("postflush_in_ready", in_ready, 1'b1);
      chk("postflush_ready", ready, 1'b0);
      step();
      @(negedge clk);
      chk("postflush2_ready", ready, 1'b0);
      chk("postflush2_count", count, 3'd0);
      step();
      run_single(vecs[6], "post_flush");

      // Asynchronous reset while the head is ready
      for (int i = 0; i < 2; i++) begin
         v = mk(6'(12 + i), 6'(55 + i), 1'b0, 32'h55, 32'(i));
         drive(v);
         step();
      end
      idle();
      wb_valid = 2'b01; wb_preg = {6'd0, 6'd55}; wb_data = {32'h0, 32'h55};
      step();
      idle();
      #1 rst = 1'b0;
      @(negedge clk);
      chk("midrst_ready", ready, 1'b0);
      chk("midrst_count", count, 3'd0);
      chk("midrst_in_ready", in_ready, 1'b1);
      step();
      rst = 1'b1;
      @(negedge clk);
      chk("after_rst_ready", ready, 1'b0);
      chk("after_rst_count", count, 3'd0);
      step();
      run_single(vecs[0], "post_reset");

      chk("scoreboard_drained", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

endmodule
